// File: rtl/mem_stage_sb.sv
// mem_stage_sb: memory stage with a posted store buffer that forwards to loads and drains to mem_system in the background.
module mem_stage_sb #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int SB_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] fwd_data_in,
  input  logic              mem_mem_fwd,
  input  logic              createdump,
  output logic [DATA_W-1:0] data_out,
  output logic              stall,
  output logic              err,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_data_in,
  output logic              m_rd,
  output logic              m_wr,
  output logic              m_createdump,
  input  logic [DATA_W-1:0] m_data_out,
  input  logic              m_done,
  input  logic              m_err
);
  localparam int PW = $clog2(SB_DEPTH);
  typedef enum logic [1:0] {IDLE, DRAIN, LOAD, DUMP} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] sb_addr [SB_DEPTH];
  logic [DATA_W-1:0] sb_data [SB_DEPTH];
  logic [PW-1:0] head, tail, idx;
  logic [PW:0] count;
  logic store, load, full, enq, deq, load_done, hit;
  logic [DATA_W-1:0] hit_data;
  assign store     = en & mem_wr;
  assign load      = en & ~mem_wr;
  assign full      = count == (PW+1)'(SB_DEPTH);
  assign enq       = store & ~full;
  assign deq       = (state == DRAIN) & m_done;
  assign load_done = (state == LOAD) & m_done;
  // Walk oldest to youngest so the youngest matching entry wins; the draining head stays visible.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = head;
    for (int i = 0; i < SB_DEPTH; i++) begin
      idx = head + PW'(i);
      if (i < int'(count) && sb_addr[idx] == addr) begin
        hit      = 1'b1;
        hit_data = sb_data[idx];
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      state <= state_nx;
      if (enq) tail <= tail + PW'(1);
      if (deq) head <= head + PW'(1);
      count <= count + (PW+1)'(enq) - (PW+1)'(deq);
    end
  end
  always_ff @(posedge clk) begin
    if (enq) begin
      sb_addr[tail] <= addr;
      sb_data[tail] <= mem_mem_fwd ? fwd_data_in : data_in;
    end
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (load & ~hit) ? LOAD : (count != '0) ? DRAIN : createdump ? DUMP : IDLE;
      DRAIN:   state_nx = m_done ? IDLE : DRAIN;
      LOAD:    state_nx = m_done ? IDLE : LOAD;
      default: state_nx = IDLE;
    endcase
  end
  assign m_rd         = state == LOAD;
  assign m_wr         = state == DRAIN;
  assign m_createdump = state == DUMP;
  assign m_addr       = m_wr ? sb_addr[head] : m_rd ? addr : '0;
  assign m_data_in    = m_wr ? sb_data[head] : '0;
  assign data_out     = (load & hit) ? hit_data : load_done ? m_data_out : '0;
  assign stall        = (store & full) | (load & ~hit & ~load_done) | (createdump & (state != DUMP));
  assign err          = m_err | (en & addr[0]);
endmodule

// File: tb/tb_mem_stage_sb.sv
// tb_mem_stage_sb: directed checks of mem_stage_sb against a latency-programmable mem_system model.
module tb_mem_stage_sb;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, mem_wr = 1'b0, mem_mem_fwd = 1'b0, createdump = 1'b0, m_err = 1'b0;
  logic [15:0] addr = '0, data_in = '0, fwd_data_in = '0;
  logic [15:0] data_out, m_addr, m_data_in, m_data_out;
  logic        stall, err, m_rd, m_wr, m_createdump, m_done;
  int          n_chk = 0, n_fail = 0;
  int          lat = 3, cnt = 0, rd_cnt = 0, md_cnt = 0;
  logic [15:0] rd_val = 16'hBEEF;
  logic [31:0] wlog [$];

  mem_stage_sb dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mem_wr(mem_wr), .addr(addr),
    .data_in(data_in), .fwd_data_in(fwd_data_in), .mem_mem_fwd(mem_mem_fwd),
    .createdump(createdump), .data_out(data_out), .stall(stall), .err(err),
    .m_addr(m_addr), .m_data_in(m_data_in), .m_rd(m_rd), .m_wr(m_wr),
    .m_createdump(m_createdump), .m_data_out(m_data_out), .m_done(m_done), .m_err(m_err)
  );

  always #5 clk = ~clk;

  // mem_system model: m_done pulses once after lat cycles of a held request
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= 0;
      m_done     <= 1'b0;
      m_data_out <= '0;
    end else begin
      m_done <= 1'b0;
      if ((m_rd || m_wr) && !m_done) begin
        if (cnt == lat - 1) begin
          cnt        <= 0;
          m_done     <= 1'b1;
          m_data_out <= m_rd ? rd_val : 16'h0;
          if (m_wr) wlog.push_back({m_addr, m_data_in});
        end else cnt <= cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_rd) rd_cnt++;
    if (m_createdump) md_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic op(input logic e, input logic w, input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    en = e; mem_wr = w; addr = a; data_in = d;
    #1;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 200 && dut.count != 0; i++) @(negedge clk);
    #1;
    chk("drain_empty", 32'(dut.count), 0);
  endtask

  initial begin
    int stalls, bad, seen, n0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_data_out", 32'(data_out), 0);
    chk("rst_m_rd", 32'(m_rd), 0);
    chk("rst_m_wr", 32'(m_wr), 0);
    chk("rst_m_dump", 32'(m_createdump), 0);
    chk("rst_m_addr", 32'(m_addr), 0);
    chk("rst_m_data_in", 32'(m_data_in), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_count", 32'(dut.count), 0);
    rst_n = 1'b1;

    // store then forwarded load of the same address
    op(1, 1, 16'h0010, 16'h1234);
    chk("st1_stall", 32'(stall), 0);
    op(1, 0, 16'h0010, 16'h0);
    chk("st1_count", 32'(dut.count), 1);
    chk("fwd1_data", 32'(data_out), 32'h1234);
    chk("fwd1_stall", 32'(stall), 0);
    chk("fwd1_err", 32'(err), 0);
    op(0, 0, 16'h0, 16'h0);
    wait_empty();
    chk("fwd1_no_rd", 32'(rd_cnt), 0);
    chk("wlog0", wlog[0], 32'h0010_1234);

    // youngest match wins; forward-path store data
    op(1, 1, 16'h0020, 16'h1111);
    op(1, 1, 16'h0020, 16'h2222);
    op(1, 0, 16'h0020, 16'h0);
    chk("young_data", 32'(data_out), 32'h2222);
    chk("young_stall", 32'(stall), 0);
    mem_mem_fwd = 1'b1;
    fwd_data_in = 16'h3333;
    op(1, 1, 16'h0020, 16'h9999);
    chk("fwdst_stall", 32'(stall), 0);
    op(1, 0, 16'h0020, 16'h0);
    mem_mem_fwd = 1'b0;
    #1;
    chk("fwdst_data", 32'(data_out), 32'h3333);
    op(0, 0, 16'h0, 16'h0);
    wait_empty();
    chk("wlog1", wlog[1], 32'h0020_1111);
    chk("wlog2", wlog[2], 32'h0020_2222);
    chk("wlog3", wlog[3], 32'h0020_3333);

    // full buffer: fifth store stalls through the first drain's m_done cycle
    lat = 5;
    for (int k = 0; k < 4; k++) begin
      op(1, 1, 16'(16'h0100 + 2 * k), 16'(16'hA000 + k));
      chk($sformatf("full_st%0d_stall", k), 32'(stall), 0);
    end
    op(1, 1, 16'h0108, 16'hA004);
    stalls = 0;
    for (int i = 0; i < 20 && stall; i++) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    chk("full_stall_cycles", 32'(stalls), 4);
    op(0, 0, 16'h0, 16'h0);
    chk("wrap_addr0", 32'(dut.sb_addr[0]), 32'h0108);
    chk("wrap_data0", 32'(dut.sb_data[0]), 32'hA004);
    chk("wrap_tail", 32'(dut.tail), 1);
    wait_empty();
    for (int k = 0; k < 5; k++)
      chk($sformatf("drain_order%0d", k), wlog[4+k], {16'(16'h0100 + 2 * k), 16'(16'hA000 + k)});

    // load miss behind a pending drain
    lat = 3;
    op(1, 1, 16'h0030, 16'h5555);
    op(0, 0, 16'h0, 16'h0);
    op(1, 0, 16'h0040, 16'h0);
    stalls = 0;
    seen = 0;
    for (int i = 0; i < 40 && stall; i++) begin
      stalls++;
      if (m_rd && seen == 0) begin
        seen = 1;
        chk("miss_rd_after_drain", 32'(dut.count), 0);
        chk("miss_no_wr", 32'(m_wr), 0);
      end
      @(negedge clk);
      #1;
    end
    chk("miss_rd_seen", 32'(seen), 1);
    chk("miss_stall_cycles", 32'(stalls), 8);
    chk("miss_data", 32'(data_out), 32'hBEEF);
    chk("miss_done_cycle", 32'(m_done), 1);
    chk("miss_drain_log", wlog[9], 32'h0030_5555);
    op(0, 0, 16'h0, 16'h0);

    // dump drains three stores, then one m_createdump cycle
    lat = 2;
    op(1, 1, 16'h0050, 16'h0001);
    op(1, 1, 16'h0052, 16'h0002);
    op(1, 1, 16'h0054, 16'h0003);
    op(0, 0, 16'h0, 16'h0);
    createdump = 1'b1;
    #1;
    bad = 0;
    for (int i = 0; i < 100 && !m_createdump; i++) begin
      if (!stall) bad++;
      @(negedge clk);
      #1;
    end
    chk("dump_stall_held", 32'(bad), 0);
    chk("dump_strobe", 32'(m_createdump), 1);
    chk("dump_stall_release", 32'(stall), 0);
    chk("dump_count", 32'(dut.count), 0);
    createdump = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("dump_once", 32'(md_cnt), 1);
    chk("dump_wr_n", 32'(wlog.size()), 13);
    chk("dump_wlog0", wlog[10], 32'h0050_0001);
    chk("dump_wlog2", wlog[12], 32'h0054_0003);

    // reset mid-LOAD
    lat = 10;
    op(1, 0, 16'h0060, 16'h0);
    for (int i = 0; i < 20 && !m_rd; i++) begin
      @(negedge clk);
      #1;
    end
    chk("rstld_issued", 32'(m_rd), 1);
    rst_n = 1'b0;
    en = 1'b0;
    #1;
    chk("rstld_m_rd", 32'(m_rd), 0);
    chk("rstld_m_addr", 32'(m_addr), 0);
    chk("rstld_stall", 32'(stall), 0);
    chk("rstld_data_out", 32'(data_out), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // reset mid-DRAIN discards queued stores
    op(1, 1, 16'h0070, 16'h7777);
    op(1, 1, 16'h0072, 16'h7778);
    op(0, 0, 16'h0, 16'h0);
    for (int i = 0; i < 20 && !m_wr; i++) begin
      @(negedge clk);
      #1;
    end
    chk("rstdr_issued", 32'(m_wr), 1);
    n0 = wlog.size();
    rst_n = 1'b0;
    #1;
    chk("rstdr_m_wr", 32'(m_wr), 0);
    chk("rstdr_m_data_in", 32'(m_data_in), 0);
    chk("rstdr_count", 32'(dut.count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    #1;
    chk("rstdr_no_write", 32'(wlog.size()), 32'(n0));
    chk("rstdr_idle", 32'(m_wr), 0);

    // error indication
    op(1, 0, 16'h0011, 16'h0);
    chk("err_odd", 32'(err), 1);
    en = 1'b0;
    #1;
    chk("err_clear", 32'(err), 0);
    m_err = 1'b1;
    #1;
    chk("err_m_err", 32'(err), 1);
    m_err = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
